// File: rtl/sram_axi_bridge.sv
// Two-port SRAM-like to AXI3 bridge: single-beat reads (per-port in-order, RD_DEPTH outstanding)
// and single-beat data-port writes. Define AXI_BRIDGE_ERR_EN to add sticky bus_err/bus_err_code.
module sram_axi_bridge #(
  parameter int RD_DEPTH = 2,
  parameter int ID_W     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inst_sram_req,
  input  logic            inst_sram_wr,
  input  logic [1:0]      inst_sram_size,
  input  logic [3:0]      inst_sram_wstrb,
  input  logic [31:0]     inst_sram_addr,
  input  logic [31:0]     inst_sram_wdata,
  output logic            inst_sram_addr_ok,
  output logic            inst_sram_data_ok,
  output logic [31:0]     inst_sram_rdata,
  input  logic            data_sram_req,
  input  logic            data_sram_wr,
  input  logic [1:0]      data_sram_size,
  input  logic [3:0]      data_sram_wstrb,
  input  logic [31:0]     data_sram_addr,
  input  logic [31:0]     data_sram_wdata,
  output logic            data_sram_addr_ok,
  output logic            data_sram_data_ok,
  output logic [31:0]     data_sram_rdata,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [2:0]      arsize,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [2:0]      awsize,
  output logic            awvalid,
  input  logic            awready,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready,
`ifdef AXI_BRIDGE_ERR_EN
  output logic            bus_err,
  output logic [1:0]      bus_err_code,
`endif
  output logic [3:0]      arlen,
  output logic [3:0]      awlen,
  output logic [1:0]      arburst,
  output logic [1:0]      awburst,
  output logic [1:0]      arlock,
  output logic [1:0]      awlock,
  output logic [3:0]      arcache,
  output logic [3:0]      awcache,
  output logic [2:0]      arprot,
  output logic [2:0]      awprot,
  output logic [ID_W-1:0] wid,
  output logic            wlast
);

  localparam int CW = $clog2(RD_DEPTH + 1);
  localparam logic [CW-1:0]   DEPTH_C = CW'(RD_DEPTH);
  localparam logic [ID_W-1:0] INST_ID = '0;
  localparam logic [ID_W-1:0] DATA_ID = ID_W'(1);

  logic          slot_free;
  logic          inst_dec, data_dec;
  logic          inst_rd_ok, data_rd_ok, data_wr_ok;
  logic          wr_pending;
  logic [CW-1:0] inst_cnt, data_cnt;
  logic          unused_sig;

  assign slot_free = !arvalid || arready;
  assign inst_dec  = rvalid && (rid == INST_ID);
  assign data_dec  = rvalid && (rid == DATA_ID);

  // A full port may still accept when a response frees an entry in the same cycle.
  assign data_rd_ok = data_sram_req && !data_sram_wr && slot_free && !wr_pending &&
                      ((data_cnt < DEPTH_C) || data_dec);
  assign inst_rd_ok = inst_sram_req && !inst_sram_wr && slot_free && !data_rd_ok &&
                      ((inst_cnt < DEPTH_C) || inst_dec);
  assign data_wr_ok = data_sram_req && data_sram_wr && !wr_pending && (data_cnt == '0) &&
                      !(arvalid && (arid == DATA_ID));

  assign inst_sram_addr_ok = inst_rd_ok;
  assign data_sram_addr_ok = data_rd_ok || data_wr_ok;
  assign inst_sram_data_ok = rvalid && !rid[0];
  assign data_sram_data_ok = (rvalid && rid[0]) || bvalid;
  assign inst_sram_rdata   = (rvalid && !rid[0]) ? rdata : 32'h0;
  assign data_sram_rdata   = (rvalid && rid[0]) ? rdata : 32'h0;

  assign rready  = 1'b1;
  assign bready  = 1'b1;
  assign awid    = DATA_ID;
  assign wid     = DATA_ID;
  assign wlast   = 1'b1;
  assign arlen   = 4'd0;
  assign awlen   = 4'd0;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign arlock  = 2'b00;
  assign awlock  = 2'b00;
  assign arcache = 4'd0;
  assign awcache = 4'd0;
  assign arprot  = 3'd0;
  assign awprot  = 3'd0;

  assign unused_sig = ^{inst_sram_wstrb, inst_sram_wdata, rlast, bid, rresp, bresp};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arvalid <= 1'b0;
      araddr  <= 32'h0;
      arsize  <= 3'd0;
      arid    <= '0;
    end else if (slot_free) begin
      if (data_rd_ok) begin
        arvalid <= 1'b1;
        araddr  <= data_sram_addr;
        arsize  <= {1'b0, data_sram_size};
        arid    <= DATA_ID;
      end else if (inst_rd_ok) begin
        arvalid <= 1'b1;
        araddr  <= inst_sram_addr;
        arsize  <= {1'b0, inst_sram_size};
        arid    <= INST_ID;
      end else begin
        arvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_cnt <= '0;
      data_cnt <= '0;
    end else begin
      if (inst_rd_ok && !inst_dec)
        inst_cnt <= inst_cnt + CW'(1);
      else if (!inst_rd_ok && inst_dec && (inst_cnt != '0))
        inst_cnt <= inst_cnt - CW'(1);
      if (data_rd_ok && !data_dec)
        data_cnt <= data_cnt + CW'(1);
      else if (!data_rd_ok && data_dec && (data_cnt != '0))
        data_cnt <= data_cnt - CW'(1);
    end
  end

  // AW and W retire independently; the write stays pending until its B response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pending <= 1'b0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      awaddr     <= 32'h0;
      awsize     <= 3'd0;
      wdata      <= 32'h0;
      wstrb      <= 4'h0;
    end else if (data_wr_ok) begin
      wr_pending <= 1'b1;
      awvalid    <= 1'b1;
      wvalid     <= 1'b1;
      awaddr     <= data_sram_addr;
      awsize     <= {1'b0, data_sram_size};
      wdata      <= data_sram_wdata;
      wstrb      <= data_sram_wstrb;
    end else begin
      if (awvalid && awready) awvalid <= 1'b0;
      if (wvalid && wready)   wvalid  <= 1'b0;
      if (bvalid)             wr_pending <= 1'b0;
    end
  end

`ifdef AXI_BRIDGE_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_err      <= 1'b0;
      bus_err_code <= 2'b00;
    end else if (!bus_err) begin
      if (rvalid && (rresp != 2'b00)) begin
        bus_err      <= 1'b1;
        bus_err_code <= rresp;
      end else if (bvalid && (bresp != 2'b00)) begin
        bus_err      <= 1'b1;
        bus_err_code <= bresp;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed self-checking bench for sram_axi_bridge (RD_DEPTH = 2); inputs change just after
// the rising edge and outputs are sampled on the falling edge.
module tb_sram_axi_bridge;

  localparam int ID_W = 4;

  logic            clk;
  logic            rst_n;
  logic            inst_sram_req, inst_sram_wr;
  logic [1:0]      inst_sram_size;
  logic [3:0]      inst_sram_wstrb;
  logic [31:0]     inst_sram_addr, inst_sram_wdata;
  logic            inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0]     inst_sram_rdata;
  logic            data_sram_req, data_sram_wr;
  logic [1:0]      data_sram_size;
  logic [3:0]      data_sram_wstrb;
  logic [31:0]     data_sram_addr, data_sram_wdata;
  logic            data_sram_addr_ok, data_sram_data_ok;
  logic [31:0]     data_sram_rdata;
  logic [ID_W-1:0] arid, rid, awid, bid, wid;
  logic [31:0]     araddr, rdata, awaddr, wdata;
  logic [2:0]      arsize, awsize, arprot, awprot;
  logic            arvalid, arready, rlast, rvalid, rready;
  logic [1:0]      rresp, bresp, arburst, awburst, arlock, awlock;
  logic            awvalid, awready, wvalid, wready, bvalid, bready, wlast;
  logic [3:0]      wstrb, arlen, awlen, arcache, awcache;
`ifdef AXI_BRIDGE_ERR_EN
  logic            bus_err;
  logic [1:0]      bus_err_code;
`endif

  int compared;
  int mismatched;

  sram_axi_bridge #(.RD_DEPTH(2), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
`ifdef AXI_BRIDGE_ERR_EN
    .bus_err(bus_err), .bus_err_code(bus_err_code),
`endif
    .arlen(arlen), .awlen(awlen), .arburst(arburst), .awburst(awburst),
    .arlock(arlock), .awlock(awlock), .arcache(arcache), .awcache(awcache),
    .arprot(arprot), .awprot(awprot), .wid(wid), .wlast(wlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic sampleNow();
    @(negedge clk);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst_n = 1'b0;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 4'h0;
    inst_sram_addr = 32'h0; inst_sram_wdata = 32'h0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 4'h0;
    data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
    arready = 1'b1; rid = '0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = 2'b00; bvalid = 1'b0;

    repeat (2) @(posedge clk);
    sampleNow();
    checkOutput("rst_arvalid", arvalid, 32'd0);
    checkOutput("rst_awvalid", awvalid, 32'd0);
    checkOutput("rst_wvalid", wvalid, 32'd0);
    checkOutput("rst_araddr", araddr, 32'h0);
    checkOutput("rst_inst_data_ok", inst_sram_data_ok, 32'd0);
    checkOutput("rst_data_data_ok", data_sram_data_ok, 32'd0);
    rst_n = 1'b1;

    // An inst-port write is never accepted.
    applyStimulus();
    inst_sram_req = 1; inst_sram_wr = 1; inst_sram_addr = 32'h1C00_0040;
    sampleNow();
    checkOutput("inst_wr_addr_ok", inst_sram_addr_ok, 32'd0);
    applyStimulus();
    inst_sram_req = 0; inst_sram_wr = 0;
    sampleNow();
    checkOutput("inst_wr_no_ar", arvalid, 32'd0);

    // Basic inst read, minimum latency.
    applyStimulus();
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0000;
    sampleNow();
    checkOutput("t1_addr_ok", inst_sram_addr_ok, 32'd1);
    applyStimulus();
    inst_sram_req = 0;
    sampleNow();
    checkOutput("t1_arvalid", arvalid, 32'd1);
    checkOutput("t1_araddr", araddr, 32'h1C00_0000);
    checkOutput("t1_arid", arid, 32'd0);
    checkOutput("t1_arsize", arsize, 32'd2);
    checkOutput("t1_arlen", arlen, 32'd0);
    checkOutput("t1_arburst", arburst, 32'd1);
    applyStimulus();
    rvalid = 1; rid = 4'd0; rdata = 32'h0280_0C05;
    sampleNow();
    checkOutput("t1_data_ok", inst_sram_data_ok, 32'd1);
    checkOutput("t1_rdata", inst_sram_rdata, 32'h0280_0C05);
    checkOutput("t1_no_cross", data_sram_data_ok, 32'd0);
    checkOutput("t1_ar_idle", arvalid, 32'd0);

    // Simultaneous requests: data first, inst next cycle; responses rid1 then rid0.
    applyStimulus();
    rvalid = 0;
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0010;
    data_sram_req = 1; data_sram_addr = 32'h8000_0000;
    sampleNow();
    checkOutput("t2_data_addr_ok", data_sram_addr_ok, 32'd1);
    checkOutput("t2_inst_blocked", inst_sram_addr_ok, 32'd0);
    applyStimulus();
    data_sram_req = 0;
    sampleNow();
    checkOutput("t2_arid_data", arid, 32'd1);
    checkOutput("t2_araddr_data", araddr, 32'h8000_0000);
    checkOutput("t2_inst_addr_ok", inst_sram_addr_ok, 32'd1);
    applyStimulus();
    inst_sram_req = 0;
    rvalid = 1; rid = 4'd1; rdata = 32'hDEAD_BEEF;
    sampleNow();
    checkOutput("t2_arid_inst", arid, 32'd0);
    checkOutput("t2_araddr_inst", araddr, 32'h1C00_0010);
    checkOutput("t2_data_ok", data_sram_data_ok, 32'd1);
    checkOutput("t2_data_rdata", data_sram_rdata, 32'hDEAD_BEEF);
    checkOutput("t2_inst_quiet", inst_sram_data_ok, 32'd0);
    checkOutput("t2_inst_rdata0", inst_sram_rdata, 32'h0);
    applyStimulus();
    rid = 4'd0; rdata = 32'h1111_2222;
    sampleNow();
    checkOutput("t2_inst_ok", inst_sram_data_ok, 32'd1);
    checkOutput("t2_inst_rdata", inst_sram_rdata, 32'h1111_2222);
    checkOutput("t2_data_quiet", data_sram_data_ok, 32'd0);

    // Depth limit: two inst reads fill the port, the third waits for a response.
    applyStimulus();
    rvalid = 0;
    inst_sram_req = 1; inst_sram_addr = 32'h0000_0100;
    sampleNow();
    checkOutput("t3_acc0", inst_sram_addr_ok, 32'd1);
    applyStimulus();
    inst_sram_addr = 32'h0000_0104;
    sampleNow();
    checkOutput("t3_acc1", inst_sram_addr_ok, 32'd1);
    applyStimulus();
    inst_sram_addr = 32'h0000_0108;
    sampleNow();
    checkOutput("t3_full", inst_sram_addr_ok, 32'd0);
    checkOutput("t3_araddr1", araddr, 32'h0000_0104);
    applyStimulus();
    sampleNow();
    checkOutput("t3_full_hold", inst_sram_addr_ok, 32'd0);
    checkOutput("t3_ar_idle", arvalid, 32'd0);
    applyStimulus();
    rvalid = 1; rid = 4'd0; rdata = 32'hA0A0_0100;
    sampleNow();
    checkOutput("t3_same_cycle_acc", inst_sram_addr_ok, 32'd1);
    checkOutput("t3_rsp0", inst_sram_rdata, 32'hA0A0_0100);
    applyStimulus();
    inst_sram_req = 0; rdata = 32'hA0A0_0104;
    sampleNow();
    checkOutput("t3_araddr2", araddr, 32'h0000_0108);
    checkOutput("t3_rsp1", inst_sram_data_ok, 32'd1);
    applyStimulus();
    rdata = 32'hA0A0_0108;
    sampleNow();
    checkOutput("t3_rsp2", inst_sram_rdata, 32'hA0A0_0108);

    // Data write with AW delayed behind W; a data read waits for the B response.
    applyStimulus();
    rvalid = 0;
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h8000_0004;
    data_sram_wdata = 32'h1234_5678; data_sram_wstrb = 4'hF;
    awready = 0; wready = 1;
    sampleNow();
    checkOutput("t4_wr_addr_ok", data_sram_addr_ok, 32'd1);
    applyStimulus();
    data_sram_req = 0; data_sram_wr = 0;
    sampleNow();
    checkOutput("t4_awvalid", awvalid, 32'd1);
    checkOutput("t4_wvalid", wvalid, 32'd1);
    checkOutput("t4_awaddr", awaddr, 32'h8000_0004);
    checkOutput("t4_wdata", wdata, 32'h1234_5678);
    checkOutput("t4_wstrb", wstrb, 32'hF);
    checkOutput("t4_awsize", awsize, 32'd2);
    checkOutput("t4_awid", awid, 32'd1);
    checkOutput("t4_wlast", wlast, 32'd1);
    applyStimulus();
    wready = 0;
    data_sram_req = 1; data_sram_addr = 32'h8000_0100;
    sampleNow();
    checkOutput("t4_wvalid_drop", wvalid, 32'd0);
    checkOutput("t4_aw_hold", awvalid, 32'd1);
    checkOutput("t4_rd_blocked", data_sram_addr_ok, 32'd0);
    applyStimulus();
    sampleNow();
    checkOutput("t4_rd_blocked2", data_sram_addr_ok, 32'd0);
    applyStimulus();
    awready = 1;
    sampleNow();
    checkOutput("t4_aw_hold2", awvalid, 32'd1);
    applyStimulus();
    awready = 0; bvalid = 1; bid = 4'd1;
    sampleNow();
    checkOutput("t4_aw_drop", awvalid, 32'd0);
    checkOutput("t4_wr_data_ok", data_sram_data_ok, 32'd1);
    checkOutput("t4_rd_blocked3", data_sram_addr_ok, 32'd0);
    applyStimulus();
    bvalid = 0;
    sampleNow();
    checkOutput("t4_rd_accept", data_sram_addr_ok, 32'd1);
    applyStimulus();
    data_sram_req = 0;
    sampleNow();
    checkOutput("t4_rd_araddr", araddr, 32'h8000_0100);
    checkOutput("t4_rd_arid", arid, 32'd1);
    applyStimulus();
    rvalid = 1; rid = 4'd1; rdata = 32'hCAFE_F00D;
    sampleNow();
    checkOutput("t4_rd_data_ok", data_sram_data_ok, 32'd1);
    checkOutput("t4_rd_rdata", data_sram_rdata, 32'hCAFE_F00D);
    applyStimulus();
    rvalid = 0;

`ifdef AXI_BRIDGE_ERR_EN
    // Sticky error capture, cleared only by reset.
    applyStimulus();
    bvalid = 1; bresp = 2'b10;
    sampleNow();
    checkOutput("e_before", bus_err, 32'd0);
    applyStimulus();
    bresp = 2'b00;
    sampleNow();
    checkOutput("e_set", bus_err, 32'd1);
    checkOutput("e_code", bus_err_code, 32'd2);
    applyStimulus();
    bvalid = 0; rvalid = 1; rid = 4'd0; rresp = 2'b00;
    sampleNow();
    checkOutput("e_sticky", bus_err, 32'd1);
    checkOutput("e_code_sticky", bus_err_code, 32'd2);
    applyStimulus();
    rvalid = 0;
    rst_n = 0;
    #1;
    checkOutput("e_reset", bus_err, 32'd0);
    checkOutput("e_code_reset", bus_err_code, 32'd0);
    rst_n = 1;
`endif

    applyStimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
